// File: rtl/decode_ctrl_pipe.sv
// rtl/decode_ctrl_pipe.sv - registered RV32I decode stage with 2-entry skid buffer
// Decodes one instruction per cycle into a control bundle; EMPTY/FULL/SKID tracks occupancy.
module decode_ctrl_pipe #(
  parameter int DATA_WIDTH     = 32,
  parameter int ALU_CTRL_WIDTH = 4,
  parameter bit KILL_X0_WRITE  = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     in_instr,
  input  logic [DATA_WIDTH-1:0]     in_pc,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_instr,
  output logic [DATA_WIDTH-1:0]     out_pc,
  output logic [ALU_CTRL_WIDTH-1:0] out_alu_ctrl,
  output logic                      out_alu_src_b,
  output logic                      out_alu_src_a,
  output logic [2:0]                out_imm_src,
  output logic [1:0]                out_result_src,
  output logic                      out_reg_write,
  output logic                      out_mem_write,
  output logic                      out_mem_read,
  output logic                      out_branch,
  output logic                      out_jump,
  output logic                      out_jalr,
  output logic                      out_illegal
);

  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_OPCODE_ADD  = ALU_CTRL_WIDTH'(0);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_OPCODE_SUB  = ALU_CTRL_WIDTH'(1);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_OPCODE_SLL  = ALU_CTRL_WIDTH'(2);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_OPCODE_SLT  = ALU_CTRL_WIDTH'(3);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_OPCODE_SLTU = ALU_CTRL_WIDTH'(4);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_OPCODE_XOR  = ALU_CTRL_WIDTH'(5);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_OPCODE_SRL  = ALU_CTRL_WIDTH'(6);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_OPCODE_SRA  = ALU_CTRL_WIDTH'(7);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_OPCODE_OR   = ALU_CTRL_WIDTH'(8);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_OPCODE_AND  = ALU_CTRL_WIDTH'(9);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_OPCODE_B    = ALU_CTRL_WIDTH'(10);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]     instr;
    logic [DATA_WIDTH-1:0]     pc;
    logic [ALU_CTRL_WIDTH-1:0] alu_ctrl;
    logic                      alu_src_b;
    logic                      alu_src_a;
    logic [2:0]                imm_src;
    logic [1:0]                result_src;
    logic                      reg_write;
    logic                      mem_write;
    logic                      mem_read;
    logic                      branch;
    logic                      jump;
    logic                      jalr;
    logic                      illegal;
  } bundle_t;

  typedef enum logic [1:0] {S_EMPTY, S_FULL, S_SKID} state_t;

  state_t  r_state;
  logic    r_in_ready;
  bundle_t r_out;
  bundle_t r_skid;
  bundle_t w_dec;
  logic    w_legal;
  logic    w_accept;
  logic    w_drain;

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;

  assign w_opcode = in_instr[6:0];
  assign w_funct3 = in_instr[14:12];
  assign w_funct7 = in_instr[31:25];

  // alt selects SUB/SRA in the funct3 slots that have a second meaning
  function automatic logic [ALU_CTRL_WIDTH-1:0] alu_of(input logic [2:0] f3, input logic alt);
    logic [ALU_CTRL_WIDTH-1:0] op;
    op = ALU_OPCODE_ADD;
    case (f3)
      3'b000: op = alt ? ALU_OPCODE_SUB : ALU_OPCODE_ADD;
      3'b001: op = ALU_OPCODE_SLL;
      3'b010: op = ALU_OPCODE_SLT;
      3'b011: op = ALU_OPCODE_SLTU;
      3'b100: op = ALU_OPCODE_XOR;
      3'b101: op = alt ? ALU_OPCODE_SRA : ALU_OPCODE_SRL;
      3'b110: op = ALU_OPCODE_OR;
      3'b111: op = ALU_OPCODE_AND;
      default: op = ALU_OPCODE_ADD;
    endcase
    return op;
  endfunction

  always_comb begin
    w_dec       = '0;
    w_dec.instr = in_instr;
    w_dec.pc    = in_pc;
    w_legal     = 1'b1;
    case (w_opcode)
      7'b0110011: begin
        w_legal = (w_funct7 == 7'h00) ||
                  (w_funct7 == 7'h20 && (w_funct3 == 3'b000 || w_funct3 == 3'b101));
        w_dec.alu_ctrl  = alu_of(w_funct3, w_funct7 == 7'h20);
        w_dec.reg_write = 1'b1;
      end
      7'b0010011: begin
        if (w_funct3 == 3'b001)      w_legal = (w_funct7 == 7'h00);
        else if (w_funct3 == 3'b101) w_legal = (w_funct7 == 7'h00) || (w_funct7 == 7'h20);
        w_dec.alu_ctrl  = alu_of(w_funct3, (w_funct3 == 3'b101) && (w_funct7 == 7'h20));
        w_dec.alu_src_b = 1'b1;
        w_dec.reg_write = 1'b1;
      end
      7'b0000011: begin
        w_legal = (w_funct3 != 3'b011) && (w_funct3 != 3'b110) && (w_funct3 != 3'b111);
        w_dec.alu_src_b  = 1'b1;
        w_dec.result_src = 2'b01;
        w_dec.mem_read   = 1'b1;
        w_dec.reg_write  = 1'b1;
      end
      7'b0100011: begin
        w_legal = (w_funct3 <= 3'b010);
        w_dec.alu_src_b = 1'b1;
        w_dec.imm_src   = 3'b001;
        w_dec.mem_write = 1'b1;
      end
      7'b1100011: begin
        w_legal = (w_funct3 != 3'b010) && (w_funct3 != 3'b011);
        w_dec.alu_ctrl = ALU_OPCODE_SUB;
        w_dec.imm_src  = 3'b010;
        w_dec.branch   = 1'b1;
      end
      7'b1101111: begin
        w_dec.alu_src_a  = 1'b1;
        w_dec.alu_src_b  = 1'b1;
        w_dec.imm_src    = 3'b100;
        w_dec.result_src = 2'b10;
        w_dec.reg_write  = 1'b1;
        w_dec.jump       = 1'b1;
      end
      7'b1100111: begin
        w_legal = (w_funct3 == 3'b000);
        w_dec.alu_src_b  = 1'b1;
        w_dec.result_src = 2'b10;
        w_dec.reg_write  = 1'b1;
        w_dec.jump       = 1'b1;
        w_dec.jalr       = 1'b1;
      end
      7'b0110111: begin
        w_dec.alu_ctrl  = ALU_OPCODE_B;
        w_dec.alu_src_b = 1'b1;
        w_dec.imm_src   = 3'b011;
        w_dec.reg_write = 1'b1;
      end
      7'b0010111: begin
        w_dec.alu_src_a = 1'b1;
        w_dec.alu_src_b = 1'b1;
        w_dec.imm_src   = 3'b011;
        w_dec.reg_write = 1'b1;
      end
      7'b1110011: w_legal = (in_instr == 32'h0000_0073) || (in_instr == 32'h0010_0073);
      7'b0001111: w_legal = 1'b1;
      default:    w_legal = 1'b0;
    endcase
    if (!w_legal) begin
      w_dec         = '0;
      w_dec.instr   = in_instr;
      w_dec.pc      = in_pc;
      w_dec.illegal = 1'b1;
    end
    if (KILL_X0_WRITE && in_instr[11:7] == 5'd0) w_dec.reg_write = 1'b0;
  end

  assign w_accept = in_valid && r_in_ready;
  assign w_drain  = (r_state != S_EMPTY) && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b1;
      r_out      <= '0;
      r_skid     <= '0;
    end else if (flush) begin
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      case (r_state)
        S_EMPTY: if (w_accept) begin
          r_out   <= w_dec;
          r_state <= S_FULL;
        end
        S_FULL: begin
          if (w_accept && w_drain) begin
            r_out <= w_dec;
          end else if (w_accept) begin
            r_skid     <= w_dec;
            r_state    <= S_SKID;
            r_in_ready <= 1'b0;
          end else if (w_drain) begin
            r_state <= S_EMPTY;
          end
        end
        S_SKID: if (w_drain) begin
          r_out      <= r_skid;
          r_state    <= S_FULL;
          r_in_ready <= 1'b1;
        end
        default: r_state <= S_EMPTY;
      endcase
    end
  end

  assign in_ready       = r_in_ready;
  assign out_valid      = (r_state != S_EMPTY);
  assign out_instr      = r_out.instr;
  assign out_pc         = r_out.pc;
  assign out_alu_ctrl   = r_out.alu_ctrl;
  assign out_alu_src_b  = r_out.alu_src_b;
  assign out_alu_src_a  = r_out.alu_src_a;
  assign out_imm_src    = r_out.imm_src;
  assign out_result_src = r_out.result_src;
  assign out_reg_write  = r_out.reg_write;
  assign out_mem_write  = r_out.mem_write;
  assign out_mem_read   = r_out.mem_read;
  assign out_branch     = r_out.branch;
  assign out_jump       = r_out.jump;
  assign out_jalr       = r_out.jalr;
  assign out_illegal    = r_out.illegal;

endmodule
